// File: rtl/fecha_edit.sv
// ============================================================================
// fecha_edit: BCD day/month/year editor driving the date holding registers.
// Optional macro LEAP_YEAR_EN enables the 29-day February in leap years.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fecha_edit #(
  parameter logic [7:0] ANIO_MIN = 8'h00,
  parameter logic [7:0] ANIO_MAX = 8'h99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_prog,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_next,
  input  logic [7:0] init_dia,
  input  logic [7:0] init_mes,
  input  logic [7:0] init_anio,
  output logic [7:0] ddia,
  output logic [7:0] dmes,
  output logic [7:0] danio,
  output logic       en_dia,
  output logic       en_mes,
  output logic       en_anio,
  output logic [1:0] campo,
  output logic       ocupado
);

  typedef enum logic [2:0] {
    S_IDLE, S_CARGA, S_E_DIA, S_E_MES, S_E_ANIO, S_FIN
  } estado_t;

  estado_t    estado_q;
  logic [7:0] ddia_q, dmes_q, danio_q;
  logic       en_dia_q, en_mes_q, en_anio_q, ocupado_q;
  logic [1:0] campo_q;

`ifdef LEAP_YEAR_EN
  // Divisible by 4 in BCD: even tens with units 0/4/8, odd tens with units 2/6.
  function automatic logic bisiesto(input logic [7:0] a);
    if (a[4]) return (a[3:0] == 4'h2) || (a[3:0] == 4'h6);
    else      return (a[3:0] == 4'h0) || (a[3:0] == 4'h4) || (a[3:0] == 4'h8);
  endfunction
`else
  function automatic logic bisiesto(input logic [7:0] a);
    return 1'b0 & (^a);
  endfunction
`endif

  function automatic logic [7:0] max_dia(input logic [7:0] mes, input logic bis);
    case (mes)
      8'h02:                      return bis ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'h9) return {v[7:4] + 4'd1, 4'h0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'h0) return {v[7:4] - 4'd1, 4'h9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'h9) && (v[3:0] <= 4'h9);
  endfunction

  logic [7:0] carga_dia_d, carga_mes_d, carga_anio_d, max_carga;
  logic [7:0] dia_d, mes_d, anio_d, max_act, max_nuevo;
  logic [8:0] anio_sobre_min, anio_bajo_max;
  logic       en_dia_d, en_mes_d, en_anio_d, btn_ok, editando;

  always_comb begin
    // Borrow-based range test keeps the year check valid for any ANIO_MIN.
    anio_sobre_min = {1'b0, init_anio} - {1'b0, ANIO_MIN};
    anio_bajo_max  = {1'b0, ANIO_MAX} - {1'b0, init_anio};
    carga_mes_d  = (bcd_ok(init_mes) && init_mes != 8'h00 && init_mes <= 8'h12) ? init_mes : 8'h01;
    carga_anio_d = (bcd_ok(init_anio) && !anio_sobre_min[8] && !anio_bajo_max[8]) ? init_anio : ANIO_MIN;
    carga_dia_d  = (bcd_ok(init_dia) && init_dia != 8'h00 && init_dia <= 8'h31) ? init_dia : 8'h01;
    max_carga    = max_dia(carga_mes_d, bisiesto(carga_anio_d));
    if (carga_dia_d > max_carga) carga_dia_d = max_carga;

    btn_ok   = (btn_up ^ btn_down) && !btn_next && mode_prog;
    editando = (estado_q == S_E_DIA) || (estado_q == S_E_MES) || (estado_q == S_E_ANIO);
    max_act  = max_dia(dmes_q, bisiesto(danio_q));
    dia_d    = ddia_q;
    mes_d    = dmes_q;
    anio_d   = danio_q;
    en_dia_d  = 1'b0;
    en_mes_d  = 1'b0;
    en_anio_d = 1'b0;
    if (btn_ok) begin
      case (estado_q)
        S_E_DIA: begin
          if (btn_up) dia_d = (ddia_q == max_act) ? 8'h01 : bcd_inc(ddia_q);
          else        dia_d = (ddia_q == 8'h01) ? max_act : bcd_dec(ddia_q);
          en_dia_d = 1'b1;
        end
        S_E_MES: begin
          if (btn_up) mes_d = (dmes_q == 8'h12) ? 8'h01 : bcd_inc(dmes_q);
          else        mes_d = (dmes_q == 8'h01) ? 8'h12 : bcd_dec(dmes_q);
          en_mes_d = 1'b1;
        end
        S_E_ANIO: begin
          if (btn_up) anio_d = (danio_q == ANIO_MAX) ? ANIO_MIN : bcd_inc(danio_q);
          else        anio_d = (danio_q == ANIO_MIN) ? ANIO_MAX : bcd_dec(danio_q);
          en_anio_d = 1'b1;
        end
        default: ;
      endcase
    end
    max_nuevo = max_dia(mes_d, bisiesto(anio_d));
    if (editando && dia_d > max_nuevo) begin
      dia_d    = max_nuevo;
      en_dia_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= S_IDLE;
      ddia_q    <= 8'h01;
      dmes_q    <= 8'h01;
      danio_q   <= ANIO_MIN;
      en_dia_q  <= 1'b0;
      en_mes_q  <= 1'b0;
      en_anio_q <= 1'b0;
      campo_q   <= 2'b11;
      ocupado_q <= 1'b0;
    end else begin
      en_dia_q  <= 1'b0;
      en_mes_q  <= 1'b0;
      en_anio_q <= 1'b0;
      case (estado_q)
        S_IDLE: if (mode_prog) begin
          estado_q  <= S_CARGA;
          ocupado_q <= 1'b1;
        end
        S_CARGA: begin
          ddia_q   <= carga_dia_d;
          dmes_q   <= carga_mes_d;
          danio_q  <= carga_anio_d;
          campo_q  <= 2'b00;
          estado_q <= S_E_DIA;
        end
        S_E_DIA, S_E_MES, S_E_ANIO: begin
          if (!mode_prog) begin
            estado_q  <= S_FIN;
            en_dia_q  <= 1'b1;
            en_mes_q  <= 1'b1;
            en_anio_q <= 1'b1;
          end else if (btn_next) begin
            case (estado_q)
              S_E_DIA: begin estado_q <= S_E_MES;  campo_q <= 2'b01; end
              S_E_MES: begin estado_q <= S_E_ANIO; campo_q <= 2'b10; end
              default: begin estado_q <= S_E_DIA;  campo_q <= 2'b00; end
            endcase
          end else begin
            ddia_q    <= dia_d;
            dmes_q    <= mes_d;
            danio_q   <= anio_d;
            en_dia_q  <= en_dia_d;
            en_mes_q  <= en_mes_d;
            en_anio_q <= en_anio_d;
          end
        end
        S_FIN: begin
          estado_q  <= S_IDLE;
          ocupado_q <= 1'b0;
          campo_q   <= 2'b11;
        end
        default: estado_q <= S_IDLE;
      endcase
    end
  end

  assign ddia    = ddia_q;
  assign dmes    = dmes_q;
  assign danio   = danio_q;
  assign en_dia  = en_dia_q;
  assign en_mes  = en_mes_q;
  assign en_anio = en_anio_q;
  assign campo   = campo_q;
  assign ocupado = ocupado_q;

endmodule

`default_nettype wire
